fifo_uart_tx: RTL and testbench

//  Downstream consumer of the 8-bit synchronous FIFO (syn_fifo).
//  - Pops bytes from the FIFO whenever it is non-empty.
//  - Serialises each byte onto a single UART-style line: start bit, 8 data bits LSB first, optional parity, stop bit.
//  - Provides the FIFO drain path to an off-chip serial link.

---
 rtl/fifo_uart_tx.sv | 178 +++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains an 8-bit synchronous FIFO onto a UART-style serial line.
//
// Each byte goes out as a frame:
//   - a start bit;
//   - 8 data bits, LSB first;
//   - an optional parity bit;
//   - a stop bit.
// Every bit lasts CLKS_PER_BIT clocks. Exactly one FIFO read is issued per frame.
// fifo_empty is only looked at while idle.
//
// Optional feature: define UART_TX_PARITY_EN to insert a parity bit between the data
// bits and the stop bit. Parity is even when PARITY_ODD == 0 and odd otherwise. When
// the macro is not defined, the frame is 10 bits and PARITY_ODD is ignored.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per serial bit (>= 2)
//   PARITY_ODD    0 = even parity, 1 = odd parity (macro builds only)
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-high reset
//   fifo_empty  FIFO empty flag
//   fifo_data   FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en  one-cycle read strobe per byte
//   tx          serial line, idles high
//   busy        high from the fetch cycle through the last stop-bit cycle
//   tx_done     one-cycle pulse in the last cycle of the stop bit

module fifo_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd_en,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    localparam int unsigned    CntW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
    localparam logic ParOdd = (PARITY_ODD != 0);
`else
    logic unused_parity_odd;
    assign unused_parity_odd = (PARITY_ODD != 0);
`endif

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StStart,
        StData,
`ifdef UART_TX_PARITY_EN
        StParity,
`endif
        StStop
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            bit_end;
    logic            tx_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        bit_end = (cnt_q == CntMax);
        tx_d    = 1'b1;

        case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                state_d = StLoad;
            end
            StLoad: begin
                shift_d = fifo_data;
                cnt_d   = '0;
                bit_d   = '0;
                state_d = StStart;
            end
            StStart: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = StData;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (bit_end) begin
                    cnt_d = '0;
                    // Rotate rather than shift: after 8 rotations the byte is intact,
                    // so its parity can still be taken from the register.
                    shift_d = {shift_q[0], shift_q[7:1]};
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = StStop;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            StStop: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        // Outputs are registered, so they are decoded from the next state.
        case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            StParity: tx_d = (^shift_d) ^ ParOdd;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            tx         <= 1'b1;
            fifo_rd_en <= 1'b0;
            busy       <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx         <= tx_d;
            fifo_rd_en <= (state_d == StFetch);
            busy       <= (state_d != StIdle);
            tx_done    <= (state_d == StStop) && (cnt_d == CntMax);
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
`timescale 1ns/1ps
// Bench for fifo_uart_tx.
// A small FIFO model feeds the DUT. A frame-level reference model predicts
// tx/busy/fifo_rd_en/tx_done every cycle. Directed scenarios add literal checks
// that pin down the timing and bit patterns.
module tb_fifo_uart_tx;

    localparam int C    = 16;
    localparam int PODD = 0;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS  = 11;
    localparam int LEN_07 = 176;
`else
    localparam int NBITS  = 10;
    localparam int LEN_07 = 160;
`endif
    localparam int FRAME = NBITS * C;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_data = 8'h00;
    logic       fifo_rd_en, tx, busy, tx_done;

    fifo_uart_tx #(
        .CLKS_PER_BIT(C),
        .PARITY_ODD  (PODD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .fifo_empty(fifo_empty),
        .fifo_data (fifo_data),
        .fifo_rd_en(fifo_rd_en),
        .tx        (tx),
        .busy      (busy),
        .tx_done   (tx_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Upstream FIFO. A write shows up on fifo_empty after the next clock edge,
    // and read data is valid the cycle after the strobe.
    logic [7:0] fq[$];
    logic [7:0] mq[$];

    always @(posedge clk) begin
        logic [7:0] b;
        if (fifo_rd_en) begin
            check("fifo_underflow", 32'(fq.size() == 0), 0);
            if (fq.size() != 0) begin
                b = fq.pop_front();
                fifo_data <= b;
            end
        end
        fifo_empty <= (fq.size() == 0);
    end

    task automatic push(input logic [7:0] b);
        fq.push_back(b);
        mq.push_back(b);
    endtask

    // Frame-level reference model.
    // m_t counts cycles from the fetch cycle:
    //   t=0      fetch
    //   t=1      load
    //   t=2..    serial bits, C cycles each
    // After the last stop-bit cycle there is one mandatory idle cycle.
    function automatic logic [NBITS-1:0] frame_bits(input logic [7:0] b);
        logic [NBITS-1:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = b;
`ifdef UART_TX_PARITY_EN
        f[9] = (^b) ^ (PODD != 0);
`endif
        return f;
    endfunction

    logic             m_active = 1'b0;
    int               m_t = 0;
    logic [NBITS-1:0] m_bits = '1;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_active <= 1'b0;
            m_t      <= 0;
        end else if (m_active) begin
            if (m_t + 1 == FRAME + 2) m_active <= 1'b0;
            else                      m_t <= m_t + 1;
        end else if (!fifo_empty && mq.size() != 0) begin
            m_active <= 1'b1;
            m_t      <= 0;
            m_bits   <= frame_bits(mq.pop_front());
        end
    end

    logic       chk_en = 1'b0;
    logic [3:0] exp_v;
    logic       exp_tx;

    always @(negedge clk) begin
        if (chk_en) begin
            if (!m_active || m_t < 2) exp_tx = 1'b1;
            else                      exp_tx = m_bits[(m_t - 2) / C];
            exp_v = {exp_tx, m_active, (m_active && m_t == 0), (m_active && m_t == FRAME + 1)};
            check("cycle{tx,busy,rd_en,done}", 32'({tx, busy, fifo_rd_en, tx_done}), 32'(exp_v));
        end
    end

    // Event log. The start of a frame is the first tx==0 cycle after a read strobe.
    int   cyc = 0;
    logic want_start = 1'b0;
    int   rd_q[$];
    int   st_q[$];
    int   dn_q[$];
    bit   tx_hist[0:8191];

    always @(negedge clk) begin
        if (cyc < 8192) tx_hist[cyc] = tx;
        if (reset) begin
            want_start = 1'b0;
        end else begin
            if (fifo_rd_en) begin
                rd_q.push_back(cyc);
                want_start = 1'b1;
            end else if (want_start && tx == 1'b0) begin
                st_q.push_back(cyc);
                want_start = 1'b0;
            end
            if (tx_done) dn_q.push_back(cyc);
        end
        cyc++;
    end

    task automatic clear_log();
        rd_q.delete();
        st_q.delete();
        dn_q.delete();
    endtask

    task automatic wait_dones(input string name, input int n, input int budget);
        int i = 0;
        while (dn_q.size() < n && i < budget) begin
            @(negedge clk);
            i++;
        end
        check(name, 32'(dn_q.size() >= n), 1);
    endtask

    // Checks one frame's latency and length.
    // Returns 0 if the event log is incomplete.
    task automatic check_frame(input string name, input int idx, output bit ok);
        ok = (rd_q.size() > idx) && (st_q.size() > idx) && (dn_q.size() > idx);
        check({name, "_logged"}, 32'(ok), 1);
        if (ok) begin
            check({name, "_latency"}, 32'(st_q[idx] - rd_q[idx]), 2);
            check({name, "_length"}, 32'(dn_q[idx] - st_q[idx] + 1), 32'(FRAME));
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         ok;
        int         s;
        int         i;
        logic [9:0] pat;

        // 1: reset held
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_tx", 32'(tx), 1);
        check("reset_busy", 32'(busy), 0);
        check("reset_rd_en", 32'(fifo_rd_en), 0);
        check("reset_done", 32'(tx_done), 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // 2: single byte A5
        clear_log();
        push(8'hA5);
        wait_dones("a5_wait", 1, 400);
        repeat (6) @(negedge clk);
        check("a5_rd_pulses", 32'(rd_q.size()), 1);
        check("a5_done_pulses", 32'(dn_q.size()), 1);
        check_frame("a5", 0, ok);
        if (ok) begin
            s = st_q[0];
            for (int b = 0; b < 9; b++) pat[b] = tx_hist[s + b * C + C / 2];
            pat[9] = tx_hist[s + (NBITS - 1) * C + C / 2];
            check("a5_bits", 32'(pat), 32'(10'b1101001010));
        end

        // 3: back-to-back 00, FF, 55
        clear_log();
        push(8'h00);
        push(8'hFF);
        push(8'h55);
        wait_dones("b2b_wait", 3, 1200);
        repeat (6) @(negedge clk);
        check("b2b_rd_pulses", 32'(rd_q.size()), 3);
        for (int f = 0; f < 3; f++) check_frame("b2b", f, ok);
        if (st_q.size() >= 3 && dn_q.size() >= 2) begin
            check("b2b_gap01", 32'(st_q[1] - dn_q[0]), 4);
            check("b2b_gap12", 32'(st_q[2] - dn_q[1]), 4);
        end else begin
            check("b2b_gap_logged", 0, 1);
        end

        // 4: FIFO stays empty
        clear_log();
        repeat (500) @(negedge clk);
        check("empty_rd_pulses", 32'(rd_q.size()), 0);
        check("empty_tx", 32'(tx), 1);
        check("empty_busy", 32'(busy), 0);

        // 5: reset during data bit 3 of C3; 3C must follow whole
        clear_log();
        push(8'hC3);
        push(8'h3C);
        i = 0;
        while (st_q.size() == 0 && i < 50) begin
            @(negedge clk);
            i++;
        end
        check("rst_mid_start_seen", 32'(st_q.size() != 0), 1);
        if (st_q.size() != 0) begin
            s = st_q[0] + C * 4 + 6;
            i = 0;
            while (cyc < s && i < 200) begin
                @(negedge clk);
                i++;
            end
        end
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("rst_mid_tx", 32'(tx), 1);
        check("rst_mid_busy", 32'(busy), 0);
        check("rst_mid_done", 32'(tx_done), 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        wait_dones("rst_next_wait", 1, 400);
        repeat (6) @(negedge clk);
        check("rst_rd_pulses", 32'(rd_q.size()), 2);
        check("rst_done_pulses", 32'(dn_q.size()), 1);
        check("rst_fifo_drained", 32'(fq.size()), 0);
        if (rd_q.size() >= 2 && st_q.size() >= 2 && dn_q.size() >= 1) begin
            check("rst_next_length", 32'(dn_q[0] - st_q[1] + 1), 32'(FRAME));
        end else begin
            check("rst_next_logged", 0, 1);
        end

        // 6: byte 07, parity bit (if present) is 1 for even parity
        clear_log();
        push(8'h07);
        wait_dones("p07_wait", 1, 400);
        repeat (6) @(negedge clk);
        if (st_q.size() >= 1 && dn_q.size() >= 1) begin
            s = st_q[0];
            check("p07_length", 32'(dn_q[0] - s + 1), 32'(LEN_07));
            check("p07_bit7", 32'(tx_hist[s + 8 * C + C / 2]), 0);
            check("p07_bit9", 32'(tx_hist[s + 9 * C + C / 2]), 1);
        end else begin
            check("p07_logged", 0, 1);
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
